// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display capture path: segment bit
// positions and the active-high glyph table used by the receive decoder.
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high glyphs, bit n = segment n (a..g). 6, 7 and 9 carry a tail
  // to match the transmit-side encoder.
  localparam seg_t GLYPH_0 = 7'h3F;
  localparam seg_t GLYPH_1 = 7'h06;
  localparam seg_t GLYPH_2 = 7'h5B;
  localparam seg_t GLYPH_3 = 7'h4F;
  localparam seg_t GLYPH_4 = 7'h66;
  localparam seg_t GLYPH_5 = 7'h6D;
  localparam seg_t GLYPH_6 = 7'h7D;
  localparam seg_t GLYPH_7 = 7'h27;
  localparam seg_t GLYPH_8 = 7'h7F;
  localparam seg_t GLYPH_9 = 7'h6F;
  localparam seg_t GLYPH_A = 7'h77;
  localparam seg_t GLYPH_B = 7'h7C;
  localparam seg_t GLYPH_C = 7'h39;
  localparam seg_t GLYPH_D = 7'h5E;
  localparam seg_t GLYPH_E = 7'h79;
  localparam seg_t GLYPH_F = 7'h71;

  // Entry [n] holds the glyph for hex value n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse 7-segment decoder: active-high segment pattern to hex value.
// hit is low when the pattern is not one of the 16 known glyphs.
module seg7_to_hex
  import display_pkg::*;
(
  input  seg_t       seg,
  output logic       hit,
  output logic [3:0] value
);

  // Search the glyph table; glyphs are unique so at most one entry matches.
  always_comb begin
    hit   = 1'b0;
    value = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH_TABLE[i]) begin
        hit   = 1'b1;
        value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/display_capture.sv
// Receive side of the scanned 4-digit 7-segment bus. Synchronises DIGIT/SEG,
// waits for a stable window, decodes the lit glyph back to hex and keeps all
// four digit positions in parallel, with a staleness timeout.
module display_capture
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 262144,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] DIGIT,
  input  logic [7:0] SEG,
  output logic [3:0] D0,
  output logic [3:0] D1,
  output logic [3:0] D2,
  output logic [3:0] D3,
  output logic [3:0] DP,
  output logic       VALID,
  output logic       FRAME,
  output logic       ERR
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       SEG_IDLE   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [11:0]      BUS_IDLE   = {4'hF, SEG_IDLE};

  // Bring the bus to active-high polarity: bit 7 = dp lit, bits 6:0 = a..g lit.
  function automatic logic [7:0] seg_normalise(input logic [7:0] raw);
    return SEG_ACTIVE_LOW ? ~raw : raw;
  endfunction

  // Position index of a single asserted select bit (caller guarantees one-hot).
  function automatic logic [1:0] sel_index(input logic [3:0] sel);
    case (sel)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  logic [11:0]      bus_p0, bus_p1, bus_p2;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             vld_p2;
  logic [3:0]       sel_p2;
  logic [7:0]       seg_n_p2;
  logic             sel_blank, sel_single;
  logic [1:0]       idx_p2;
  logic             glyph_hit;
  logic [3:0]       glyph_val;
  logic             cap_hit, cap_err;
  logic [3:0]       mask, mask_nxt;
  logic [TO_W-1:0]  tcnt, tcnt_nxt;
  logic [3:0]       dig [4];

  // ---- stage p0/p1: two-flop synchroniser, p2: previous synced value ----
  // Synchroniser plus one history flop used for change detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus_p0 <= BUS_IDLE;
      bus_p1 <= BUS_IDLE;
      bus_p2 <= BUS_IDLE;
    end else begin
      bus_p0 <= {DIGIT, SEG};
      bus_p1 <= bus_p0;
      bus_p2 <= bus_p1;
    end
  end

  // Stability counter: restart and re-arm on any change, saturate when settled,
  // disarm after one evaluation so each stable window is captured once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (bus_p1 != bus_p2) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else begin
      if (cnt != SETTLE_MAX) cnt <= cnt + CNT_W'(1);
      if (vld_p2) armed <= 1'b0;
    end
  end

  // ---- stage p2: evaluate the settled pattern ----
  assign vld_p2     = armed && (cnt == SETTLE_MAX);
  assign sel_p2     = ~bus_p2[11:8];
  assign seg_n_p2   = seg_normalise(bus_p2[7:0]);
  assign sel_blank  = (sel_p2 == 4'b0000);
  assign sel_single = $onehot(sel_p2);
  assign idx_p2     = sel_index(sel_p2);

  seg7_to_hex u_dec (
    .seg   (seg_n_p2[6:0]),
    .hit   (glyph_hit),
    .value (glyph_val)
  );

  // Capture outcome, next capture mask and timeout count; a capture beats a timeout.
  always_comb begin
    cap_hit  = vld_p2 && sel_single && glyph_hit;
    cap_err  = vld_p2 && !sel_blank && !(sel_single && glyph_hit);
    mask_nxt = mask;
    tcnt_nxt = tcnt + TO_W'(1);
    if (cap_hit) begin
      mask_nxt[idx_p2] = 1'b1;
      tcnt_nxt         = '0;
    end else if (tcnt == TO_LAST) begin
      mask_nxt = '0;
      tcnt_nxt = '0;
    end
  end

  // ---- stage p3: output registers ----
  // Digit/dp storage, mask, staleness counter and the FRAME/ERR pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) dig[i] <= 4'h0;
      DP    <= 4'h0;
      mask  <= 4'h0;
      tcnt  <= '0;
      VALID <= 1'b0;
      FRAME <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      if (cap_hit) begin
        dig[idx_p2] <= glyph_val;
        DP[idx_p2]  <= seg_n_p2[SEG_DP];
      end
      mask  <= mask_nxt;
      tcnt  <= tcnt_nxt;
      VALID <= &mask_nxt;
      FRAME <= cap_hit && (idx_p2 == 2'd3) && (&mask_nxt);
      ERR   <= cap_err;
    end
  end

  assign D0 = dig[0];
  assign D1 = dig[1];
  assign D2 = dig[2];
  assign D3 = dig[3];

endmodule

// File: tb/tb_display_capture.sv
// Scoreboard bench for display_capture: stimulus pushes the expected output
// snapshot for every visible output event, a monitor pops and compares.
module tb_display_capture;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] DIGIT = 4'hF;
  logic [7:0] SEG = 8'hFF;
  logic [3:0] D0, D1, D2, D3, DP;
  logic       VALID, FRAME, ERR;

  display_capture #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(64),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .DIGIT(DIGIT),
    .SEG  (SEG),
    .D0   (D0),
    .D1   (D1),
    .D2   (D2),
    .D3   (D3),
    .DP   (DP),
    .VALID(VALID),
    .FRAME(FRAME),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] d0, d1, d2, d3, dp;
    logic       valid, frame, err;
  } snap_t;

  snap_t cur;
  assign cur = {D0, D1, D2, D3, DP, VALID, FRAME, ERR};

  snap_t exp_q[$];
  string name_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  bit    mon_en       = 1'b0;

  task automatic push(input string nm, input logic [3:0] a, b, c, d, dp,
                      input logic v, f, e);
    exp_q.push_back({a, b, c, d, dp, v, f, e});
    name_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the n-th following posedge.
  task automatic drive(input logic [3:0] dg, input logic [7:0] sg, input int n);
    DIGIT = dg;
    SEG   = sg;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    DIGIT = 4'hF;
    SEG   = 8'hFF;
    RST   = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic scan();
    drive(4'hE, 8'hC0, 20);
    drive(4'hD, 8'hF9, 20);
    drive(4'hB, 8'hA4, 20);
    drive(4'h7, 8'hB0, 20);
  endtask

  // Monitor: any change of digits/dp/VALID, or a FRAME/ERR pulse, is one event.
  initial begin
    snap_t prev;
    snap_t e;
    string nm;
    prev = '0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (cur.frame || cur.err ||
            ({cur.d0, cur.d1, cur.d2, cur.d3, cur.dp, cur.valid} !==
             {prev.d0, prev.d1, prev.d2, prev.d3, prev.dp, prev.valid})) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_event: got %h, expected no event", cur);
          end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (cur !== e) begin
              tests_failed++;
              $display("FAIL %s: got %h, expected %h", nm, cur, e);
            end
          end
        end
        prev = cur;
      end else begin
        prev = cur;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("reset_state", 32'(cur), 32'h0);
    mon_en = 1'b1;

    // Test 1: full scan 0,1,2,3 (D0=0 matches reset value, so no visible event)
    push("scan_d1", 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    push("scan_d2", 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    push("scan_d3_frame", 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0);
    scan();

    // Test 2: exact latency and decimal point
    push("rst_t2", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    push("d0_eight", 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    DIGIT = 4'hE;
    SEG   = 8'h80;
    repeat (7) @(posedge CLK);
    #1;
    chk("latency_t6_old", 32'(D0), 32'h0);
    @(posedge CLK);
    #1;
    chk("latency_t7_new", 32'(D0), 32'h8);
    repeat (12) @(posedge CLK);
    #1;
    push("d0_eight_dp", 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0);
    drive(4'hE, 8'h00, 20);
    chk("dp0_lit", 32'(DP), 32'h1);

    // Test 3: illegal digit select, then unknown glyph
    push("err_multi", 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b1);
    drive(4'hC, 8'hC0, 10);
    push("err_noglyph", 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b1);
    drive(4'hD, 8'hFF, 10);
    chk("err_d1_kept", 32'(D1), 32'h0);

    // Test 4: glitching shorter than the settle window, then a steady 1
    for (int i = 0; i < 8; i++) drive(4'hE, (i % 2 == 0) ? 8'hC0 : 8'hF9, 2);
    push("glitch_then_one", 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(4'hE, 8'hF9, 20);

    // Test 5: timeout drops VALID, digits hold, next scan restores VALID/FRAME
    push("rst_t5", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    push("t5_d1", 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    push("t5_d2", 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    push("t5_d3_frame", 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0);
    drive(4'hE, 8'hC0, 20);
    drive(4'hD, 8'hF9, 20);
    drive(4'hB, 8'hA4, 20);
    DIGIT = 4'h7;
    SEG   = 8'hB0;
    repeat (8) @(posedge CLK);
    #1;
    chk("t5_valid_up", 32'(VALID), 32'h1);
    repeat (12) @(posedge CLK);
    #1;
    push("timeout_valid_low", 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0);
    DIGIT = 4'hF;
    SEG   = 8'hFF;
    repeat (51) @(posedge CLK);
    #1;
    chk("timeout_minus1_valid", 32'(VALID), 32'h1);
    @(posedge CLK);
    #1;
    chk("timeout_valid_low", 32'(VALID), 32'h0);
    chk("timeout_digits_hold", {16'h0, D0, D1, D2, D3}, 32'h0123);
    repeat (18) @(posedge CLK);
    #1;
    push("frame_again", 4'h0, 4'h1, 4'h2, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0);
    scan();

    // Test 6: reset mid-window on D3, recapture needs a full fresh window
    DIGIT = 4'h7;
    SEG   = 8'hF9;
    repeat (3) @(posedge CLK);
    #1;
    push("rst_mid_window", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_mid_outputs", 32'(cur), 32'h0);
    push("rst_recapture_d3", 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge CLK);
    #1;
    chk("rst_recap_early", 32'(D3), 32'h0);
    @(posedge CLK);
    #1;
    chk("rst_recap_d3", 32'(D3), 32'h1);
    chk("rst_recap_noframe", 32'(FRAME), 32'h0);
    chk("rst_recap_novalid", 32'(VALID), 32'h0);
    repeat (20) @(posedge CLK);
    #1;

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
